can_reg_bank_param: RTL

//  Parametrised CAN controller register bank: address-decoded host access, configuration outputs,

---
 rtl/can_reg_bank_param.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/can_reg_bank_param.sv
// Host-visible register bank of the CAN controller: config, W1C interrupts, TX staging,
// RX prefetch and NUM_AF acceptance-filter pairs, all with a fixed one-cycle ack.
module can_reg_bank_param #(
  parameter int NUM_AF = 4,
  parameter int IRQ_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset,
  input  logic                     i_req,
  input  logic                     i_r_neg_w,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata,
  output logic                     o_ack,
  output logic                     o_error,
  output logic                     o_interrupt,
  output logic                     o_soft_reset,
  output logic                     o_cen,
  output logic                     o_sleep,
  output logic                     o_lback,
  output logic [31:0]              o_btr,
  input  logic [15:0]              i_ecr,
  input  logic [15:0]              i_sr,
  input  logic [IRQ_W-1:0]         i_irq_set,
  output logic [127:0]             o_tx_data,
  output logic                     o_tx_w_en,
  input  logic                     i_tx_full,
  input  logic [127:0]             i_rx_data,
  input  logic                     i_rx_empty,
  output logic                     o_rx_r_en,
  output logic [NUM_AF-1:0]        o_uaf,
  output logic [NUM_AF*32-1:0]     o_afmr,
  output logic [NUM_AF*32-1:0]     o_afir
);

  localparam int ISR_W = IRQ_W + 2;

  localparam logic [ADDR_W-1:0] A_SRR    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_MSR    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_BTR    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_ECR    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_SR     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_ISR    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_IER    = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_ICR    = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_TX_ID  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_TX_DLC = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] A_TX_DW1 = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] A_TX_DW2 = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] A_RX_ID  = ADDR_W'(12);
  localparam logic [ADDR_W-1:0] A_RX_DLC = ADDR_W'(13);
  localparam logic [ADDR_W-1:0] A_RX_DW1 = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] A_RX_DW2 = ADDR_W'(15);
  localparam logic [ADDR_W-1:0] A_AFR    = ADDR_W'(16);

  typedef enum logic {RX_EMPTY, RX_HOLD} rx_state_t;

  rx_state_t                rx_state_reg, rx_state_next;
  logic                     cen_reg, sleep_reg, lback_reg;
  logic [31:0]              btr_reg;
  logic [ISR_W-1:0]         isr_reg, isr_next, ier_reg;
  logic [31:0]              tx_id_reg, tx_dlc_reg, tx_dw1_reg, tx_dw2_reg;
  logic [31:0]              rx_id_reg, rx_dlc_reg, rx_dw1_reg, rx_dw2_reg;
  logic [NUM_AF-1:0]        afr_reg;
  logic [NUM_AF-1:0][31:0]  afmr_reg, afir_reg;

  logic                     is_rd, is_wr, wr_ok, acc_err, soft_rst;
  logic                     txovf_evt, rxuflw_evt, rx_load, rx_addr;
  logic [31:0]              rd_val;
  logic [NUM_AF-1:0]        af_mr_hit, af_ir_hit;
  logic                     af_hit;

  assign is_rd    = i_req & i_r_neg_w;
  assign is_wr    = i_req & ~i_r_neg_w;
  assign wr_ok    = is_wr & ~acc_err;
  assign soft_rst = wr_ok & (i_addr == A_SRR) & i_wdata[0];
  assign rx_addr  = (i_addr >= A_RX_ID) && (i_addr <= A_RX_DW2);

  // Filter k occupies the word pair starting at 0x11 + 2k.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_AF; gi++) begin : g_af
      assign af_mr_hit[gi] = (i_addr == ADDR_W'(17 + 2 * gi));
      assign af_ir_hit[gi] = (i_addr == ADDR_W'(18 + 2 * gi));
    end
  endgenerate
  assign af_hit = |{af_mr_hit, af_ir_hit};

  always_comb begin
    acc_err = 1'b0;
    rd_val  = '0;
    case (i_addr)
      A_SRR:    rd_val = {30'b0, cen_reg, 1'b0};
      A_MSR:    rd_val = {30'b0, lback_reg, sleep_reg};
      A_BTR: begin
        rd_val  = btr_reg;
        acc_err = ~i_r_neg_w & cen_reg;
      end
      A_ECR: begin
        rd_val  = {16'b0, i_ecr};
        acc_err = ~i_r_neg_w;
      end
      A_SR: begin
        rd_val  = {16'b0, i_sr};
        acc_err = ~i_r_neg_w;
      end
      A_ISR: begin
        rd_val  = 32'(isr_reg);
        acc_err = ~i_r_neg_w;
      end
      A_IER:    rd_val = 32'(ier_reg);
      A_ICR:    acc_err = i_r_neg_w;
      A_TX_ID:  rd_val = tx_id_reg;
      A_TX_DLC: rd_val = tx_dlc_reg;
      A_TX_DW1: rd_val = tx_dw1_reg;
      A_TX_DW2: begin
        rd_val  = tx_dw2_reg;
        acc_err = ~i_r_neg_w & i_tx_full;
      end
      // An RX read with nothing prefetched returns zero; the underflow is flagged in ISR.
      A_RX_ID: begin
        rd_val  = (rx_state_reg == RX_HOLD) ? rx_id_reg : 32'b0;
        acc_err = ~i_r_neg_w;
      end
      A_RX_DLC: begin
        rd_val  = (rx_state_reg == RX_HOLD) ? rx_dlc_reg : 32'b0;
        acc_err = ~i_r_neg_w;
      end
      A_RX_DW1: begin
        rd_val  = (rx_state_reg == RX_HOLD) ? rx_dw1_reg : 32'b0;
        acc_err = ~i_r_neg_w;
      end
      A_RX_DW2: begin
        rd_val  = (rx_state_reg == RX_HOLD) ? rx_dw2_reg : 32'b0;
        acc_err = ~i_r_neg_w;
      end
      A_AFR: begin
        rd_val  = 32'(afr_reg);
        acc_err = ~i_r_neg_w & cen_reg;
      end
      default: begin
        if (af_hit) begin
          for (int k = 0; k < NUM_AF; k++) begin
            if (af_mr_hit[k]) rd_val = afmr_reg[k];
            if (af_ir_hit[k]) rd_val = afir_reg[k];
          end
          acc_err = ~i_r_neg_w & cen_reg;
        end else begin
          acc_err = 1'b1;
        end
      end
    endcase
  end

  assign txovf_evt  = is_wr & (i_addr == A_TX_DW2) & i_tx_full;
  assign rxuflw_evt = is_rd & rx_addr & (rx_state_reg == RX_EMPTY);

  // Set beats clear when both hit the same bit in one cycle.
  always_comb begin
    isr_next = isr_reg;
    if (wr_ok && (i_addr == A_ICR)) isr_next = isr_next & ~i_wdata[ISR_W-1:0];
    isr_next = isr_next | {rxuflw_evt, txovf_evt, i_irq_set};
    if (soft_rst) isr_next = '0;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_load       = 1'b0;
    if (soft_rst) begin
      rx_state_next = RX_EMPTY;
    end else begin
      case (rx_state_reg)
        RX_EMPTY: if (!i_rx_empty) begin
          rx_load       = 1'b1;
          rx_state_next = RX_HOLD;
        end
        RX_HOLD:  if (is_rd && (i_addr == A_RX_DW2)) rx_state_next = RX_EMPTY;
        default:  rx_state_next = RX_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_state_reg <= RX_EMPTY;
      rx_id_reg    <= '0;
      rx_dlc_reg   <= '0;
      rx_dw1_reg   <= '0;
      rx_dw2_reg   <= '0;
      o_rx_r_en    <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      o_rx_r_en    <= rx_load;
      if (soft_rst) begin
        rx_id_reg  <= '0;
        rx_dlc_reg <= '0;
        rx_dw1_reg <= '0;
        rx_dw2_reg <= '0;
      end else if (rx_load) begin
        {rx_id_reg, rx_dlc_reg, rx_dw1_reg, rx_dw2_reg} <= i_rx_data;
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      cen_reg      <= 1'b0;
      sleep_reg    <= 1'b0;
      lback_reg    <= 1'b0;
      btr_reg      <= '0;
      isr_reg      <= '0;
      ier_reg      <= '0;
      tx_id_reg    <= '0;
      tx_dlc_reg   <= '0;
      tx_dw1_reg   <= '0;
      tx_dw2_reg   <= '0;
      afr_reg      <= '0;
      afmr_reg     <= '0;
      afir_reg     <= '0;
      o_rdata      <= '0;
      o_ack        <= 1'b0;
      o_error      <= 1'b0;
      o_interrupt  <= 1'b0;
      o_soft_reset <= 1'b0;
      o_tx_w_en    <= 1'b0;
    end else begin
      o_ack        <= i_req;
      o_error      <= i_req & acc_err;
      o_rdata      <= (is_rd && !acc_err) ? rd_val : 32'b0;
      o_interrupt  <= |(isr_reg & ier_reg);
      o_soft_reset <= soft_rst;
      o_tx_w_en    <= wr_ok & (i_addr == A_TX_DW2);
      isr_reg      <= isr_next;
      if (soft_rst) begin
        cen_reg    <= 1'b0;
        sleep_reg  <= 1'b0;
        lback_reg  <= 1'b0;
        btr_reg    <= '0;
        ier_reg    <= '0;
        tx_id_reg  <= '0;
        tx_dlc_reg <= '0;
        tx_dw1_reg <= '0;
        tx_dw2_reg <= '0;
        afr_reg    <= '0;
        afmr_reg   <= '0;
        afir_reg   <= '0;
      end else if (wr_ok) begin
        case (i_addr)
          A_SRR:    cen_reg <= i_wdata[1];
          A_MSR:    {lback_reg, sleep_reg} <= i_wdata[1:0];
          A_BTR:    btr_reg <= i_wdata;
          A_IER:    ier_reg <= i_wdata[ISR_W-1:0];
          A_TX_ID:  tx_id_reg <= i_wdata;
          A_TX_DLC: tx_dlc_reg <= i_wdata;
          A_TX_DW1: tx_dw1_reg <= i_wdata;
          A_TX_DW2: tx_dw2_reg <= i_wdata;
          A_AFR:    afr_reg <= i_wdata[NUM_AF-1:0];
          default: begin
            for (int k = 0; k < NUM_AF; k++) begin
              if (af_mr_hit[k]) afmr_reg[k] <= i_wdata;
              if (af_ir_hit[k]) afir_reg[k] <= i_wdata;
            end
          end
        endcase
      end
    end
  end

  assign o_cen     = cen_reg;
  assign o_sleep   = sleep_reg;
  assign o_lback   = lback_reg;
  assign o_btr     = btr_reg;
  assign o_tx_data = {tx_id_reg, tx_dlc_reg, tx_dw1_reg, tx_dw2_reg};
  assign o_uaf     = afr_reg;
  assign o_afmr    = afmr_reg;
  assign o_afir    = afir_reg;

endmodule
